// File: rtl/bist_session_ctrl_if.sv
// bist_session_ctrl_if: start/signature/scan-enable and status bundle between BIST controller and its user
interface bist_session_ctrl_if #(
  parameter int SIG_W = 8
);
  logic             start;
  logic             sign;
  logic             SE;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] sig;
  modport master (output start, sign, input SE, busy, done, pass, sig);
  modport slave  (input start, sign, output SE, busy, done, pass, sig);
endinterface

// File: rtl/bist_session_ctrl.sv
// bist_session_ctrl: sequences shift/capture BIST sessions on SE, collects the serial signature and checks it against GOLDEN
module bist_session_ctrl #(
  parameter int               SHIFT_LEN    = 14,
  parameter int               CAPTURE_LEN  = 1,
  parameter int               NUM_SESSIONS = 4,
  parameter int               SIG_W        = 8,
  parameter logic [SIG_W-1:0] GOLDEN       = 8'hA5
) (
  input logic               CLK,
  input logic               RSTn,
  bist_session_ctrl_if.slave bus
);
  localparam int CMAX = SHIFT_LEN > CAPTURE_LEN ? SHIFT_LEN : CAPTURE_LEN;
  localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;
  localparam int SW   = NUM_SESSIONS > 1 ? $clog2(NUM_SESSIONS) : 1;
  typedef enum logic [2:0] {IDLE, SHIFT, CAPTURE, COMPARE, DONE} state_t;
  state_t           state;
  logic [CW-1:0]    cyc_cnt;
  logic [SW-1:0]    sess_cnt;
  logic [SIG_W-1:0] sig;
  logic             se, busy, done, pass;
  assign bus.SE   = se;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.pass = pass;
  assign bus.sig  = sig;
  // outputs are registered alongside the state so they change only on the launching edge
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= IDLE;
      cyc_cnt  <= '0;
      sess_cnt <= '0;
      sig      <= '0;
      se       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) begin
          state    <= SHIFT;
          cyc_cnt  <= '0;
          sess_cnt <= '0;
          sig      <= '0;
          se       <= 1'b1;
          busy     <= 1'b1;
          done     <= 1'b0;
          pass     <= 1'b0;
        end
        SHIFT: begin
          sig <= {sig[SIG_W-2:0], bus.sign};
          if (cyc_cnt == CW'(SHIFT_LEN - 1)) begin
            state   <= CAPTURE;
            cyc_cnt <= '0;
            se      <= 1'b0;
          end else cyc_cnt <= cyc_cnt + CW'(1);
        end
        CAPTURE: if (cyc_cnt == CW'(CAPTURE_LEN - 1)) begin
          cyc_cnt <= '0;
          if (sess_cnt == SW'(NUM_SESSIONS - 1)) state <= COMPARE;
          else begin
            sess_cnt <= sess_cnt + SW'(1);
            state    <= SHIFT;
            se       <= 1'b1;
          end
        end else cyc_cnt <= cyc_cnt + CW'(1);
        COMPARE: begin
          pass  <= sig == GOLDEN;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bist_session_ctrl.sv
// tb_bist_session_ctrl: randomized runs with a queue scoreboard checking SE timing, latency and signature/pass
module tb_bist_session_ctrl;
  localparam int         SL = 14, CL = 1, NS = 4;
  localparam int         RUNLEN = NS * (SL + CL);
  localparam int         NSMP = NS * SL;
  localparam logic [7:0] GOLD = 8'hA5;
  logic CLK = 1'b0, RSTn = 1'b0;
  always #5 CLK = ~CLK;
  bist_session_ctrl_if #(.SIG_W(8)) bus ();
  bist_session_ctrl dut (.CLK(CLK), .RSTn(RSTn), .bus(bus));
  typedef struct {logic se; logic busy; logic done; logic first;} cyc_t;
  typedef struct {logic [7:0] sig; logic pass; int e0;} res_t;
  cyc_t cyc_q[$];
  res_t res_q[$];
  int tests = 0, fails = 0, edges = 0;
  always @(posedge CLK) edges++;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask
  // monitor: per-cycle waveform entries and one result per rising done
  initial begin
    cyc_t c;
    res_t r;
    logic pd = 1'b0;
    forever begin
      @(negedge CLK);
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        chk("se", 32'(bus.SE), 32'(c.se));
        chk("busy", 32'(bus.busy), 32'(c.busy));
        chk("done", 32'(bus.done), 32'(c.done));
        if (c.first) begin
          chk("restart_sig", 32'(bus.sig), 0);
          chk("restart_pass", 32'(bus.pass), 0);
        end
      end
      if (bus.done && !pd) begin
        if (res_q.size() > 0) begin
          r = res_q.pop_front();
          chk("sig", 32'(bus.sig), 32'(r.sig));
          chk("pass", 32'(bus.pass), 32'(r.pass));
          chk("latency", 32'(edges - r.e0), 32'(RUNLEN + 1));
        end else chk("unexpected_done", 1, 0);
      end
      pd = bus.done;
    end
  end
  // mode 0: signature forced to GOLD, 1: forced to GOLD^1, else random; abort_k>=0 resets mid-run
  task automatic run(input int mode, input int abort_k);
    logic s[NSMP];
    logic [7:0] exp_sig;
    int smp = 0;
    for (int i = 0; i < NSMP; i++) s[i] = 1'($urandom);
    for (int j = 0; j < 8; j++)
      if (mode == 0) s[NSMP-1-j] = GOLD[j];
      else if (mode == 1) s[NSMP-1-j] = GOLD[j] ^ (j == 0);
    for (int j = 0; j < 8; j++) exp_sig[j] = s[NSMP-1-j];
    bus.start = 1'b1;
    @(posedge CLK);
    #1;
    res_q.push_back('{exp_sig, exp_sig == GOLD, edges});
    for (int k = 0; k <= RUNLEN; k++) begin
      logic sh;
      if (k > 0) begin
        @(posedge CLK);
        #1;
      end
      sh = k < RUNLEN && (k % (SL + CL)) < SL;
      cyc_q.push_back('{sh, 1'b1, 1'b0, k == 0});
      if (sh) bus.sign = s[smp++];
      else bus.sign = 1'($urandom);
      bus.start = 1'($urandom);
      if (k == abort_k) begin
        #2 RSTn = 1'b0;
        #1;
        chk("rst_se", 32'(bus.SE), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_pass", 32'(bus.pass), 0);
        chk("rst_sig", 32'(bus.sig), 0);
        cyc_q.delete();
        res_q.delete();
        bus.start = 1'b0;
        @(posedge CLK);
        #1 RSTn = 1'b1;
        repeat (3) begin
          cyc_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
          @(posedge CLK);
          #1;
        end
        return;
      end
    end
    @(posedge CLK);
    #1 bus.start = 1'b0;
    repeat ($urandom_range(1, 3)) begin
      cyc_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
      @(posedge CLK);
      #1;
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.sign  = 1'b0;
    #12;
    chk("por_se", 32'(bus.SE), 0);
    chk("por_done", 32'(bus.done), 0);
    chk("por_sig", 32'(bus.sig), 0);
    @(posedge CLK);
    #1 RSTn = 1'b1;
    repeat (2) begin
      cyc_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
      @(posedge CLK);
      #1;
    end
    run(0, -1);
    run(1, -1);
    run(2, 5);
    run(0, -1);
    for (int i = 0; i < 6; i++) run($urandom_range(0, 2), -1);
    run(2, 20);
    run(1, -1);
    repeat (4) @(posedge CLK);
    chk("results_pending", 32'(res_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
